// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Holds the SRAM wait-state encoding and default access latency.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sram_state_t;

    localparam int DEFAULT_SRAM_LATENCY = 6;

endpackage

// File: rtl/sram_wait_fsm.sv
// SRAM wait-state sequencer: holds MEM for a fixed access latency.
// Raises mem_stall while waiting and pulses mem_ready on completion.
module sram_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int SRAM_LATENCY = DEFAULT_SRAM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic mem_stall,
    output logic mem_ready
);

    localparam logic [3:0] LOAD = 4'(SRAM_LATENCY - 2);

    sram_state_t state;
    logic [3:0]  cnt;

    // State and wait counter; dropping req mid-wait aborts the access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= WAIT;
                        cnt   <= LOAD;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall starts in the same cycle the request is first seen
    always_comb begin
        mem_stall = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            mem_stall = (state == WAIT) || ((state == IDLE) && req);
            mem_ready = (state == DONE);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Combines SRAM waits, branches and hazards; counts stalls and flushes.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int SRAM_LATENCY = DEFAULT_SRAM_LATENCY,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_id_exe,
    output logic             freeze_exe_mem,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             flush_mem_wb,
    output logic             mem_ready,
    output logic             mem_stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic req;

    assign req = mem_r_en | mem_w_en;

    sram_wait_fsm #(
        .SRAM_LATENCY(SRAM_LATENCY)
    ) u_sram (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mem_stall(mem_stall),
        .mem_ready(mem_ready)
    );

    // Priority: SRAM stall, then branch squash, then hazard bubble
    always_comb begin
        freeze_pc      = 1'b0;
        freeze_if_id   = 1'b0;
        freeze_id_exe  = 1'b0;
        freeze_exe_mem = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_exe   = 1'b0;
        flush_mem_wb   = 1'b0;
        if (rst) begin
            flush_mem_wb = 1'b0;
        end else if (mem_stall) begin
            freeze_pc      = 1'b1;
            freeze_if_id   = 1'b1;
            freeze_id_exe  = 1'b1;
            freeze_exe_mem = 1'b1;
            flush_mem_wb   = 1'b1;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
        end else if (hazard_detected) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            flush_id_exe = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (freeze_pc && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_if_id && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit.
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_pipeline_control_unit;

    localparam logic [8:0] O_NONE     = 9'b000000000;
    localparam logic [8:0] O_STALL    = 9'b111100101;
    localparam logic [8:0] O_READY    = 9'b000000010;
    localparam logic [8:0] O_BR       = 9'b000011000;
    localparam logic [8:0] O_HZ       = 9'b110001000;
    localparam logic [8:0] O_BR_READY = 9'b000011010;

    typedef struct {
        logic [8:0]  o;
        logic [15:0] sc;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_detected = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_r_en = 1'b0;
    logic mem_w_en = 1'b0;
    logic freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem;
    logic flush_if_id, flush_id_exe, flush_mem_wb;
    logic mem_ready, mem_stall;
    logic [15:0] stall_count, flush_count;

    logic hazard2 = 1'b0;
    logic [6:0] unused2;
    logic [1:0] misc2;
    logic [3:0] stall_count2, flush_count2;

    exp_t q[$];
    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [15:0] exp_fc = 16'd0;

    always #5 clk = ~clk;

    pipeline_control_unit #(.SRAM_LATENCY(6), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
        .freeze_id_exe(freeze_id_exe), .freeze_exe_mem(freeze_exe_mem),
        .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
        .flush_mem_wb(flush_mem_wb), .mem_ready(mem_ready),
        .mem_stall(mem_stall), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    pipeline_control_unit #(.SRAM_LATENCY(6), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard2), .branch_taken(1'b0),
        .mem_r_en(1'b0), .mem_w_en(1'b0),
        .freeze_pc(unused2[6]), .freeze_if_id(unused2[5]),
        .freeze_id_exe(unused2[4]), .freeze_exe_mem(unused2[3]),
        .flush_if_id(unused2[2]), .flush_id_exe(unused2[1]),
        .flush_mem_wb(unused2[0]), .mem_ready(misc2[1]),
        .mem_stall(misc2[0]), .stall_count(stall_count2),
        .flush_count(flush_count2)
    );

    function automatic logic [8:0] outv();
        return {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
                flush_if_id, flush_id_exe, flush_mem_wb,
                mem_ready, mem_stall};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, want);
    endtask

    task automatic step(input logic hz, input logic br, input logic r,
                        input logic w, input logic [8:0] o,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        hazard_detected = hz;
        branch_taken = br;
        mem_r_en = r;
        mem_w_en = w;
        e.o = o;
        e.sc = exp_sc;
        e.fc = exp_fc;
        e.nm = nm;
        q.push_back(e);
        if (o[8]) exp_sc++;
        if (o[4]) exp_fc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out"}, {23'd0, outv()}, 32'd0);
        chk({nm, "_sc"}, {16'd0, stall_count}, 32'd0);
        chk({nm, "_fc"}, {16'd0, flush_count}, 32'd0);
    endtask

    // Monitor: compare one queued expectation per cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, "_out"}, {23'd0, outv()}, {23'd0, e.o});
            chk({e.nm, "_sc"}, {16'd0, stall_count}, {16'd0, e.sc});
            chk({e.nm, "_fc"}, {16'd0, flush_count}, {16'd0, e.fc});
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_init");
        #3;
        rst = 1'b0;

        step(0, 0, 0, 0, O_NONE, "idle");
        step(1, 0, 0, 0, O_HZ, "hazard");
        step(0, 0, 0, 0, O_NONE, "post_hz");
        step(1, 1, 0, 0, O_BR, "br_hz");
        step(0, 0, 0, 0, O_NONE, "post_br");
        drain();

        rst = 1'b1;
        hazard_detected = 1'b1;
        branch_taken = 1'b1;
        mem_r_en = 1'b1;
        mem_w_en = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        hazard_detected = 1'b0;
        branch_taken = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        #2;
        rst = 1'b0;
        exp_sc = 16'd0;
        exp_fc = 16'd0;
        #1;
        chk_zero("rst_release");

        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, O_STALL, "load");
        step(0, 0, 0, 0, O_READY, "load_ready");
        step(0, 0, 0, 0, O_NONE, "post_load");

        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, O_STALL, "st_br");
        step(0, 1, 0, 0, O_BR_READY, "st_br_done");
        step(0, 0, 0, 0, O_NONE, "post_st_br");

        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, O_STALL, "b2b_a");
        step(0, 0, 1, 0, O_READY, "b2b_a_ready");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, O_STALL, "b2b_b");
        step(0, 0, 0, 0, O_READY, "b2b_b_ready");
        step(0, 0, 0, 0, O_NONE, "post_b2b");

        step(0, 0, 1, 0, O_STALL, "abort_req");
        step(0, 0, 1, 0, O_STALL, "abort_wait");
        step(0, 0, 0, 0, O_STALL, "abort_drop");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, O_NONE, "post_abort");

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, O_STALL, "rwait");
        drain();
        rst = 1'b1;
        #1;
        chk_zero("rst_mid_wait");
        mem_r_en = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("rst_mid_held");
        #3;
        rst = 1'b0;
        exp_sc = 16'd0;
        exp_fc = 16'd0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, O_NONE, "post_rst");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, O_STALL, "reload");
        step(0, 0, 0, 0, O_READY, "reload_ready");
        step(0, 0, 0, 0, O_NONE, "post_reload");
        drain();

        @(posedge clk);
        #1;
        hazard2 = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("sat_14", {28'd0, stall_count2}, 32'd14);
        repeat (6) @(posedge clk);
        #1;
        hazard2 = 1'b0;
        chk("sat_20", {28'd0, stall_count2}, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
